mem_port_sched: RTL and testbench
=================================

// Module: mem_port_sched
// PURPOSE
//  Sequences the single shared instruction/data memory port of the MIPS core.
//  Arbitrates between instruction fetch and LW/SW data accesses.
//  Drives the memory's active-low strobes (mem_enable, mem_read, mem_write) for a fixed-latency access.
//  Returns read data to the winning requester with a one-cycle ack.
//  Sits between the fetch/execute stages and the memory macro; stall holds the PC and pipeline.
// PARAMETERS
//  AW            32  address width
//  DW            32  data width
//  LAT           2   memory access cycles with strobes asserted (>=1)
//  MAX_DATA_RUN  4   consecutive data grants allowed while fetch waits (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  if_req     in   1   fetch request; held until if_ack
//  if_addr    in   AW  fetch address
//  if_ack     out  1   one-cycle pulse: fetch done, if_rdata valid
//  if_rdata   out  DW  fetched instruction
//  d_req      in   1   data request; held until d_ack
//  d_we       in   1   1=store (SW), 0=load (LW)
//  d_addr     in   AW  data address
//  d_wdata    in   DW  store data
//  d_ack      out  1   one-cycle pulse: data access done
//  d_rdata    out  DW  load data
//  stall      out  1   combinational: (if_req&~if_ack)|(d_req&~d_ack)
//  mem_enable out  1   active-low chip enable
//  mem_read   out  1   active-low read strobe
//  mem_write  out  1   active-low write strobe
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, valid in last ACCESS cycle
// BEHAVIOUR
//  Reset (async, immediate) puts the block in this state:
//   state IDLE; mem_enable=mem_read=mem_write=1; mem_addr=0; mem_wdata=0.
//   if_ack=d_ack=0; if_rdata=d_rdata=0; streak=0; access counter=0.
//  All outputs except stall are registered.
//  FSM IDLE -> ACCESS -> ACK -> IDLE.
//   IDLE:   if any req, arbitrate.
//           Latch winner's addr/we/wdata into mem_addr/mem_wdata.
//           Assert mem_enable=0, plus mem_read=0 (fetch/load) or mem_write=0 (store).
//           Go to ACCESS.
//   ACCESS: strobes and address held stable for exactly LAT cycles.
//           On the last cycle, sample mem_rdata into the winner's rdata (reads only).
//           Go to ACK.
//   ACK:    all strobes=1; winner's ack=1 for this cycle only; go to IDLE.
//  Latency: req seen at edge 0 -> strobes low cycles 1..LAT -> ack in cycle LAT+1.
//  Throughput: one access per LAT+2 cycles.
//  Requests are arbitrated only in IDLE.
//   A req still high during ACK is ignored; the requester drops it after seeing ack.
//  Priority:
//   Data wins over fetch, unless streak==MAX_DATA_RUN and if_req=1; then fetch wins.
//   streak increments on a data grant while if_req=1.
//   streak clears on a fetch grant or whenever if_req=0 in IDLE; saturates at MAX_DATA_RUN.
//  Store: mem_read stays 1; d_rdata keeps its previous value; d_ack still pulses.
//  Req withdrawn mid-access: the access completes and ack pulses anyway.
//  Reset mid-access: strobes deassert immediately and no ack is issued.
//   Requests still high after reset release are re-arbitrated from IDLE.
//  Access counter width $clog2(LAT+1); it counts down and never wraps.
// STRUCTURE
//  Package mips_mem_pkg:
//   state enum {IDLE, ACCESS, ACK}.
//   STROBE_ON=1'b0, STROBE_OFF=1'b1.
//   GNT_IF/GNT_D winner encoding.
//  Sub-module mem_grant_arb: priority + streak counter; outputs the one-cycle grant select.
// TESTING (LAT=2 unless noted)
//  1 rst=1 with reqs high -> strobes=1, acks=0, stall=1; rst=0 -> regrant in IDLE.
//  2 Fetch: if_addr=0x10, mem_rdata=0x8C080004.
//    -> mem_enable=0, mem_read=0 in cycles 1-2.
//    -> if_ack=1 with if_rdata=0x8C080004 in cycle 3.
//  3 Store: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF.
//    -> mem_write=0 and mem_read=1 in cycles 1-2; mem_wdata=0xDEADBEEF.
//    -> d_ack in cycle 3; d_rdata unchanged.
//  4 if_req and d_req rise together -> data served first, fetch acked 4 cycles later.
//  5 MAX_DATA_RUN=2, d_req and if_req held high -> grant order D,D,I,D,D,I.
//  6 rst pulse in ACCESS cycle 1 -> strobes=1 in the same timestep; no ack.
//    After release, the held request completes normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS memory-port scheduler: FSM states, strobe levels
// and the encoding of which requester owns the current access.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_e;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_grant_arb.sv
// Fetch/data priority arbiter: data normally wins, but after MAX_DATA_RUN
// back-to-back data grants with fetch waiting, fetch gets one turn.
module mem_grant_arb
  import mips_mem_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic gnt_valid,
  output gnt_e gnt_sel
);

  localparam int SW = $clog2(MAX_DATA_RUN + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_RUN);

  logic [SW-1:0] streak_q, streak_d;

  // Streak only moves on arbitration cycles; a quiet fetch side resets it.
  always_comb begin
    gnt_valid = arb_en & (if_req | d_req);
    gnt_sel   = (d_req && !(if_req && (streak_q == STREAK_MAX))) ? GNT_D : GNT_IF;
    streak_d  = streak_q;
    if (arb_en) begin
      if (!if_req) begin
        streak_d = '0;
      end else if (gnt_sel == GNT_D) begin
        if (streak_q != STREAK_MAX) begin
          streak_d = streak_q + 1'b1;
        end
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_sched.sv
// Sequencer for the shared instruction/data memory port: arbitrates fetch vs
// LW/SW, drives active-low strobes for LAT cycles, then pulses the winner's ack.
module mem_port_sched
  import mips_mem_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int LAT          = 2,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          stall,
  output logic          mem_enable,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  gnt_e          winner_q, winner_d;
  logic          we_q, we_d;
  logic          mem_enable_q, mem_enable_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic gnt_valid;
  gnt_e gnt_sel;

  mem_grant_arb #(
    .MAX_DATA_RUN(MAX_DATA_RUN)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .arb_en   (state_q == IDLE),
    .if_req   (if_req),
    .d_req    (d_req),
    .gnt_valid(gnt_valid),
    .gnt_sel  (gnt_sel)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    winner_d     = winner_q;
    we_d         = we_q;
    mem_enable_d = mem_enable_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          winner_d     = gnt_sel;
          we_d         = (gnt_sel == GNT_D) && d_we;
          mem_addr_d   = (gnt_sel == GNT_D) ? d_addr : if_addr;
          if (we_d) begin
            mem_wdata_d = d_wdata;
          end
          mem_enable_d = STROBE_ON;
          mem_read_d   = we_d ? STROBE_OFF : STROBE_ON;
          mem_write_d  = we_d ? STROBE_ON : STROBE_OFF;
          cnt_d        = CNT_LOAD;
          state_d      = ACCESS;
        end
      end
      // Strobes drop on the edge that ends the last access cycle, so the ACK
      // cycle already sees them high alongside the registered ack pulse.
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
        if (cnt_q == CNT_LAST) begin
          mem_enable_d = STROBE_OFF;
          mem_read_d   = STROBE_OFF;
          mem_write_d  = STROBE_OFF;
          state_d      = ACK;
          if (winner_q == GNT_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      winner_q     <= GNT_IF;
      we_q         <= 1'b0;
      mem_enable_q <= STROBE_OFF;
      mem_read_q   <= STROBE_OFF;
      mem_write_q  <= STROBE_OFF;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      winner_q     <= winner_d;
      we_q         <= we_d;
      mem_enable_q <= mem_enable_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign if_ack     = if_ack_q;
  assign d_ack      = d_ack_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign mem_enable = mem_enable_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign stall      = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: table-driven single accesses, hand-written
// arbitration/reset sequences, then random traffic against a transaction model.
module tb_mem_port_sched;

  localparam int LAT  = 2;
  localparam int MAXR = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        stall;
  logic        mem_enable;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '1;

  int total = 0;
  int bad = 0;

  mem_port_sched #(
    .AW(32), .DW(32), .LAT(LAT), .MAX_DATA_RUN(MAXR)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .stall(stall),
    .mem_enable(mem_enable), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h10) return 32'h8C08_0004;
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  // Memory macro: data is only valid in the LAT-th strobed cycle, garbage before.
  int strobe_cnt = 0;
  always @(negedge clk) begin
    if (mem_enable == 1'b0) begin
      strobe_cnt = strobe_cnt + 1;
      mem_rdata = (strobe_cnt == LAT) ? memval(mem_addr) : (32'hBAD0_0000 | strobe_cnt);
    end else begin
      strobe_cnt = 0;
      mem_rdata = 32'hFFFF_FFFF;
    end
  end

  // Transaction-level reference: each idle edge with a request starts an access
  // occupying LAT strobe cycles, one ack cycle, then idle again.
  logic        model_on = 1'b0;
  int          edge_n = 0;
  int          free_at = 0;
  int          streak = 0;
  int          g_edge = -100;
  logic        g_d = 1'b0;
  logic        g_we = 1'b0;
  logic [31:0] g_addr = '0;
  logic [31:0] g_wdata = '0;
  logic        pick_d;
  assign pick_d = d_req && !(if_req && (streak == MAXR));

  always @(posedge clk) begin
    if (!model_on) begin
      edge_n  <= 0;
      free_at <= 0;
      streak  <= 0;
      g_edge  <= -100;
    end else begin
      edge_n <= edge_n + 1;
      if (edge_n + 1 >= free_at) begin
        if (if_req || d_req) begin
          g_d     <= pick_d;
          g_we    <= pick_d && d_we;
          g_addr  <= pick_d ? d_addr : if_addr;
          g_wdata <= d_wdata;
          g_edge  <= edge_n + 1;
          free_at <= edge_n + 1 + LAT + 2;
        end
        if (!if_req) streak <= 0;
        else if (pick_d) streak <= (streak < MAXR) ? streak + 1 : MAXR;
        else streak <= 0;
      end
    end
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_read_n;
    logic        exp_write_n;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic dw, input logic [31:0] da, input logic [31:0] dwd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dwd;
  endtask

  task automatic runVec(input vec_t v);
    if (v.is_d) applyStimulus(1'b0, '0, 1'b1, v.we, v.addr, v.wdata);
    else applyStimulus(1'b1, v.addr, 1'b0, 1'b0, '0, '0);
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      if (k <= LAT) begin
        checkOutput("vec_enable", mem_enable, 0);
        checkOutput("vec_read", mem_read, v.exp_read_n);
        checkOutput("vec_write", mem_write, v.exp_write_n);
        checkOutput("vec_addr", mem_addr, v.addr);
        if (v.we) checkOutput("vec_wdata", mem_wdata, v.wdata);
        checkOutput("vec_stall", stall, 1);
      end else if (k == LAT + 1) begin
        checkOutput("vec_strobes_off", {mem_enable, mem_read, mem_write}, 3'b111);
        checkOutput("vec_if_ack", if_ack, !v.is_d);
        checkOutput("vec_d_ack", d_ack, v.is_d);
        checkOutput("vec_ack_stall", stall, 0);
        if (v.is_d) checkOutput("vec_d_rdata", d_rdata, v.exp_rdata);
        else checkOutput("vec_if_rdata", if_rdata, v.exp_rdata);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      end else begin
        checkOutput("vec_acks_low", {if_ack, d_ack}, 0);
      end
    end
  endtask

  // Holds each request until its ack, reporting the cycle the ack arrived.
  task automatic drain(input int budget, output int if_at, output int d_at);
    if_at = -1;
    d_at  = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (if_ack && if_at < 0) begin
        if_at  = c;
        if_req = 1'b0;
      end
      if (d_ack && d_at < 0) begin
        d_at  = c;
        d_req = 1'b0;
      end
      if (!if_req && !d_req) break;
    end
    if (if_req || d_req) begin
      checkOutput("drain_timeout", {if_req, d_req}, 0);
      if_req = 1'b0;
      d_req  = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ia, da, n;
    logic ord[6];
    logic exp_ord[6];
    logic [31:0] exp_if_rd, exp_d_rd;
    int e;
    logic in_win, ack_now, e_if_ack, e_d_ack;

    vecs[0] = '{1'b0, 1'b0, 32'h10,   32'h0,         1'b0, 1'b1, 32'h8C08_0004};
    vecs[1] = '{1'b1, 1'b0, 32'h44,   32'h0,         1'b0, 1'b1, memval(32'h44)};
    vecs[2] = '{1'b1, 1'b1, 32'h40,   32'hDEAD_BEEF, 1'b1, 1'b0, memval(32'h44)};
    vecs[3] = '{1'b0, 1'b0, 32'h2000, 32'h0,         1'b0, 1'b1, memval(32'h2000)};
    exp_ord = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset with both requests pending.
    rst = 1'b1;
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, '0);
    repeat (2) @(negedge clk);
    checkOutput("rst_strobes", {mem_enable, mem_read, mem_write}, 3'b111);
    checkOutput("rst_acks", {if_ack, d_ack}, 0);
    checkOutput("rst_stall", stall, 1);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_wdata", mem_wdata, 0);
    checkOutput("rst_rdata", if_rdata | d_rdata, 0);
    rst = 1'b0;
    drain(40, ia, da);
    checkOutput("rst_regrant_d_at", da, 3);
    checkOutput("rst_regrant_if_at", ia, 7);
    checkOutput("rst_regrant_d_rdata", d_rdata, memval(32'h200));
    checkOutput("rst_regrant_if_rdata", if_rdata, memval(32'h100));
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) runVec(vecs[i]);
    repeat (2) @(negedge clk);

    // Simultaneous rise: data first, fetch four cycles later.
    applyStimulus(1'b1, 32'h300, 1'b1, 1'b0, 32'h400, '0);
    drain(40, ia, da);
    checkOutput("both_d_at", da, 3);
    checkOutput("both_if_at", ia, 7);
    repeat (2) @(negedge clk);

    // Both held high: fetch breaks in after MAXR data grants.
    applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 32'h600, '0);
    n = 0;
    for (int c = 0; c < 80 && n < 6; c++) begin
      @(negedge clk);
      if (d_ack) begin ord[n] = 1'b1; n++; end
      else if (if_ack) begin ord[n] = 1'b0; n++; end
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("order_count", n, 6);
    for (int i = 0; i < 6; i++) begin
      if (i < n) checkOutput($sformatf("order%0d", i), ord[i], exp_ord[i]);
    end
    repeat (3) @(negedge clk);

    // Reset in the first access cycle.
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("midrst_enable_before", mem_enable, 0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_strobes", {mem_enable, mem_read, mem_write}, 3'b111);
    checkOutput("midrst_ack", if_ack, 0);
    @(negedge clk);
    checkOutput("midrst_ack_held", {if_ack, d_ack}, 0);
    checkOutput("midrst_stall", stall, 1);
    rst = 1'b0;
    drain(40, ia, da);
    checkOutput("midrst_if_at", ia, 3);
    checkOutput("midrst_if_rdata", if_rdata, 32'h8C08_0004);
    repeat (2) @(negedge clk);

    // Random traffic against the transaction model.
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    exp_if_rd = '0;
    exp_d_rd  = '0;
    @(negedge clk);
    rst = 1'b0;
    model_on = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      e = edge_n;
      in_win  = (e >= g_edge) && (e < g_edge + LAT);
      ack_now = (e == g_edge + LAT);
      e_if_ack = ack_now && !g_d;
      e_d_ack  = ack_now && g_d;
      if (ack_now && !g_we) begin
        if (g_d) exp_d_rd = memval(g_addr);
        else exp_if_rd = memval(g_addr);
      end
      checkOutput("rnd_enable", mem_enable, !in_win);
      checkOutput("rnd_read", mem_read, !(in_win && !g_we));
      checkOutput("rnd_write", mem_write, !(in_win && g_we));
      if (in_win) checkOutput("rnd_addr", mem_addr, g_addr);
      if (in_win && g_we) checkOutput("rnd_wdata", mem_wdata, g_wdata);
      checkOutput("rnd_if_ack", if_ack, e_if_ack);
      checkOutput("rnd_d_ack", d_ack, e_d_ack);
      checkOutput("rnd_if_rdata", if_rdata, exp_if_rd);
      checkOutput("rnd_d_rdata", d_rdata, exp_d_rd);
      checkOutput("rnd_stall", stall, (if_req && !e_if_ack) || (d_req && !e_d_ack));
      if (if_req && if_ack) begin
        if_req = 1'b0;
      end else if (!if_req && $urandom_range(0, 99) < 40) begin
        if_req  = 1'b1;
        if_addr = $urandom;
      end
      if (d_req && d_ack) begin
        d_req = 1'b0;
      end else if (!d_req && $urandom_range(0, 99) < 50) begin
        d_req   = 1'b1;
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
    end
    model_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
